// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect request, decode handshake.
//   imem_addr   fetch -> memory   word address
//   imem_rdata  memory -> fetch   data for the address issued one cycle earlier
//   redir_valid/redir_pc          branch/jump redirect into fetch
//   if_valid/if_ready             decode handshake
//   if_pc/if_instr                presented {pc, instr} pair
//   halted                        HALT captured, fetch stopped
// master = the fetch unit's view; slave = the surrounding memory/decode view.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              if_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_instr;
  logic              halted;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redir_valid,
    input  redir_pc,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redir_valid,
    output redir_pc,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr,
    input  halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage in front of a one-cycle-latency instruction memory.
// Owns the PC, issues one word address per cycle while output credit allows, captures
// the returned word and queues {pc, instr} pairs for decode on a valid/ready handshake.
// A redirect flushes everything and restarts at redir_pc; a HALT opcode stops fetching.
// Ports:
//   clka   rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_unit_if.master (memory port, redirect, decode handshake, halted)
module fetch_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       PC_STEP    = 1,
  parameter int unsigned       FIFO_DEPTH = 3,
  parameter logic [5:0]        HALT_OPC   = 6'b011111
) (
  input  logic         clka,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] issue_pc_q, issue_pc_d;
  logic              inflight_q, inflight_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [ADDR_W-1:0] pc_mem    [FIFO_DEPTH];
  logic [DATA_W-1:0] instr_mem [FIFO_DEPTH];

  logic            redir;
  logic            capture;
  logic            halt_capture;
  logic            credit_ok;
  logic            issue;
  logic            push;
  logic            pop;
  logic            fifo_valid;
  logic [CntW:0]   occ_total;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    // Depth need not be a power of two, so wrap explicitly.
    if (p == PtrW'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Datapath control
  always_comb begin
    redir        = bus.redir_valid;
    capture      = inflight_q;
    halt_capture = capture && (bus.imem_rdata[31:26] == HALT_OPC);
    fifo_valid   = (count_q != '0);
    // Credit counts buffered entries plus the response still in flight, so a push
    // can never find the buffer full.
    occ_total    = {1'b0, count_q} + (CntW + 1)'(inflight_q);
    credit_ok    = occ_total < (CntW + 1)'(FIFO_DEPTH);
    issue        = (state_q == StRun) && credit_ok && !redir && !halt_capture;
    // A redirect discards both the arriving response and any same-cycle pop.
    push         = capture && !redir;
    pop          = fifo_valid && bus.if_ready && !redir;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (push && halt_capture) begin
          state_d = StHalt;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StBoot;
    endcase
    if (redir) begin
      state_d = StRun;
    end
  end

  // PC, in-flight tracking and FIFO bookkeeping
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    inflight_d = issue;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redir) begin
      fetch_pc_d = bus.redir_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        issue_pc_d = fetch_pc_q;
        // Wraps modulo 2^ADDR_W by truncation.
        fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      end
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clka) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= issue_pc_q;
      instr_mem[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  always_comb begin
    bus.imem_addr = fetch_pc_q;
    bus.if_valid  = fifo_valid;
    bus.if_pc     = fifo_valid ? pc_mem[rd_ptr_q] : '0;
    bus.if_instr  = fifo_valid ? instr_mem[rd_ptr_q] : '0;
    bus.halted    = (state_q == StHalt);
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] WORD_DEF  = 32'h003F0000;
  localparam logic [31:0] WORD_ONE  = 32'h781F0000;
  localparam logic [31:0] WORD_HALT = 32'h7C1F0000;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_b_n;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  fetch_unit_if #(.ADDR_W(4),  .DATA_W(32)) bus_b ();

  fetch_unit u_dut_a (
    .clka  (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  fetch_unit #(
    .ADDR_W   (4),
    .RESET_PC (4'd14)
  ) u_dut_b (
    .clka  (clk),
    .rst_n (rst_b_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd1:   return WORD_ONE;
      32'd7:   return WORD_HALT;
      default: return WORD_DEF;
    endcase
  endfunction

  // One-cycle read latency memory models.
  always @(posedge clk) bus_a.imem_rdata <= mem_word(bus_a.imem_addr);
  assign bus_b.imem_rdata  = WORD_DEF;
  assign bus_b.redir_valid = 1'b0;
  assign bus_b.redir_pc    = 4'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [31:0] pc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (bus_a.if_valid && bus_a.if_pc == pc) found = 1'b1;
      else step();
    end
    check("wait_pc", 64'(found), 64'd1);
  endtask

  // Program-order reference: accepted pcs follow exp_pc upward from the last reset or
  // redirect target, each carrying mem_word(pc), and nothing follows a HALT word.
  logic [31:0] exp_pc;
  bit          exp_done;
  bit          hold_prev;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic [31:0] exp_word;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc    = 32'd0;
      exp_done  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("stall_valid", 64'(bus_a.if_valid), 64'd1);
        check("stall_pc", 64'(bus_a.if_pc), 64'(prev_pc));
        check("stall_instr", 64'(bus_a.if_instr), 64'(prev_instr));
      end
      if (bus_a.redir_valid) begin
        exp_pc    = bus_a.redir_pc;
        exp_done  = 1'b0;
        hold_prev = 1'b0;
      end else begin
        if (bus_a.if_valid && bus_a.if_ready) begin
          exp_word = mem_word(exp_pc);
          check("after_halt", 64'(exp_done), 64'd0);
          check("model_pc", 64'(bus_a.if_pc), 64'(exp_pc));
          check("model_instr", 64'(bus_a.if_instr), 64'(exp_word));
          if (exp_word[31:26] == 6'b011111) begin
            check("halted_on_halt_word", 64'(bus_a.halted), 64'd1);
            exp_done = 1'b1;
          end else begin
            exp_pc = exp_pc + 32'd1;
          end
        end
        hold_prev  = bus_a.if_valid && !bus_a.if_ready;
        prev_pc    = bus_a.if_pc;
        prev_instr = bus_a.if_instr;
      end
    end
  end

  // Narrow-PC instance: record the first accepted pcs.
  logic [3:0]  b_pcs[$];
  logic [31:0] b_instrs[$];
  always @(negedge clk) begin
    if (rst_b_n && bus_b.if_valid && bus_b.if_ready && b_pcs.size() < 8) begin
      b_pcs.push_back(bus_b.if_pc);
      b_instrs.push_back(bus_b.if_instr);
    end
  end

  initial begin
    rst_n             = 1'b0;
    rst_b_n           = 1'b0;
    bus_a.if_ready    = 1'b1;
    bus_a.redir_valid = 1'b0;
    bus_a.redir_pc    = 32'd0;
    bus_b.if_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_valid", 64'(bus_a.if_valid), 64'd0);
    check("rst_if_pc", 64'(bus_a.if_pc), 64'd0);
    check("rst_if_instr", 64'(bus_a.if_instr), 64'd0);
    check("rst_halted", 64'(bus_a.halted), 64'd0);
    check("rst_imem_addr", 64'(bus_a.imem_addr), 64'd0);
    check("rst_b_imem_addr", 64'(bus_b.imem_addr), 64'd14);
    rst_n   = 1'b1;
    rst_b_n = 1'b1;

    // Boot, then one address per cycle; first valid two cycles after first issue.
    step(); check("addr_c1", 64'(bus_a.imem_addr), 64'd0);
    check("valid_c1", 64'(bus_a.if_valid), 64'd0);
    step(); check("addr_c2", 64'(bus_a.imem_addr), 64'd1);
    step(); check("addr_c3", 64'(bus_a.imem_addr), 64'd2);
    check("valid_c3", 64'(bus_a.if_valid), 64'd1);
    check("pc_c3", 64'(bus_a.if_pc), 64'd0);
    step(); check("pc_c4", 64'(bus_a.if_pc), 64'd1);
    check("instr_c4", 64'(bus_a.if_instr), 64'(WORD_ONE));

    // Stall five cycles with pc 3 at the head.
    wait_pc(32'd3);
    bus_a.if_ready = 1'b0;
    repeat (4) begin
      step();
      check("stall_hold_valid", 64'(bus_a.if_valid), 64'd1);
      check("stall_hold_pc", 64'(bus_a.if_pc), 64'd3);
    end
    step();
    bus_a.if_ready = 1'b1;

    // Run to the HALT word.
    wait_pc(32'd7);
    check("halt_instr", 64'(bus_a.if_instr), 64'(WORD_HALT));
    check("halt_flag", 64'(bus_a.halted), 64'd1);
    repeat (6) step();
    check("halt_drained", 64'(bus_a.if_valid), 64'd0);
    check("halt_addr", 64'(bus_a.imem_addr), 64'd8);
    check("halt_stays", 64'(bus_a.halted), 64'd1);

    // Redirect out of halt.
    bus_a.redir_valid = 1'b1;
    bus_a.redir_pc    = 32'd0;
    step();
    bus_a.redir_valid = 1'b0;
    check("redir_unhalt", 64'(bus_a.halted), 64'd0);
    check("redir_valid_drop", 64'(bus_a.if_valid), 64'd0);
    check("redir_addr", 64'(bus_a.imem_addr), 64'd0);
    step(); check("redir_gap", 64'(bus_a.if_valid), 64'd0);
    step(); check("redir_first_valid", 64'(bus_a.if_valid), 64'd1);
    check("redir_first_pc", 64'(bus_a.if_pc), 64'd0);

    // Flush with 4,5 buffered and 6 in flight.
    wait_pc(32'd4);
    bus_a.if_ready = 1'b0;
    step();
    check("flush_head", 64'(bus_a.if_pc), 64'd4);
    bus_a.redir_valid = 1'b1;
    bus_a.redir_pc    = 32'd2;
    step();
    bus_a.redir_valid = 1'b0;
    bus_a.if_ready    = 1'b1;
    check("flush_valid", 64'(bus_a.if_valid), 64'd0);
    check("flush_addr", 64'(bus_a.imem_addr), 64'd2);
    step();
    step(); check("flush_pc2", 64'(bus_a.if_pc), 64'd2);
    check("flush_pc2_valid", 64'(bus_a.if_valid), 64'd1);
    step(); check("flush_pc3", 64'(bus_a.if_pc), 64'd3);

    // Async reset with a full buffer.
    bus_a.if_ready = 1'b0;
    repeat (3) step();
    check("full_valid", 64'(bus_a.if_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(bus_a.if_valid), 64'd0);
    check("async_rst_addr", 64'(bus_a.imem_addr), 64'd0);
    check("async_rst_pc", 64'(bus_a.if_pc), 64'd0);
    repeat (2) step();

    // 4-bit PC wrap from 14.
    check("wrap_count", 64'(b_pcs.size() >= 4), 64'd1);
    if (b_pcs.size() >= 4) begin
      check("wrap_pc0", 64'(b_pcs[0]), 64'd14);
      check("wrap_pc1", 64'(b_pcs[1]), 64'd15);
      check("wrap_pc2", 64'(b_pcs[2]), 64'd0);
      check("wrap_pc3", 64'(b_pcs[3]), 64'd1);
      check("wrap_instr", 64'(b_instrs[2]), 64'(WORD_DEF));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
